btn_scan_ctrl: RTL and testbench
================================

BTN_SCAN_CTRL -- requirements
Module: btn_scan_ctrl

Interface
REQ-001 Parameter N_BTN, default 4, number of button inputs (2..8).
REQ-002 Parameter DEBOUNCE_CNT, default 20'hFFFF, stable cycles needed to accept a level change (2..2^20-1).
REQ-003 Parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 BTN_IN  in  N_BTN  raw asynchronous button levels, active-high = pressed.
REQ-007 BTN_LEVEL  out  N_BTN  debounced button levels.
REQ-008 EVT_VALID  out  1  event FIFO non-empty.
REQ-009 EVT_READY  in  1  consumer accepts head event when high with EVT_VALID.
REQ-010 EVT_ID  out  3  button index of head event.
REQ-011 EVT_PRESS  out  1  head event type: 1 press, 0 release.
REQ-012 OVF  out  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-013 Each BTN_IN bit SHALL pass a 2-FF synchronizer; "sync level" means the second stage.
REQ-014 One shared 20-bit stability timer SHALL serve all buttons, time-multiplexed by a 3-state FSM: SCAN, QUAL, REPORT.
REQ-015 SCAN: round-robin pointer PTR examines one button per cycle; sync level == BTN_LEVEL[PTR] -> PTR advances (wrap N_BTN-1 -> 0); mismatch -> lock PTR, clear timer, go QUAL.
REQ-016 QUAL: timer increments each cycle while sync level of PTR differs from BTN_LEVEL[PTR]; if sync level reverts -> abort, PTR advances, go SCAN, no event.
REQ-017 QUAL: timer == DEBOUNCE_CNT-1 with mismatch still present -> BTN_LEVEL[PTR] toggles on that edge, go REPORT.
REQ-018 REPORT: one cycle; pushes event {PTR, new level} if event type enabled (REQ-030/031); PTR advances; go SCAN.
REQ-019 Latency: BTN_LEVEL toggles exactly DEBOUNCE_CNT cycles after the QUAL-entry edge; event visible on EVT_VALID the cycle after REPORT when FIFO was empty.
REQ-020 Changes on non-locked buttons are ignored during QUAL/REPORT and picked up on later scan passes.
REQ-021 FIFO: push in REPORT, pop when EVT_VALID & EVT_READY; EVT_ID/EVT_PRESS show head entry, hold stable while EVT_VALID & ~EVT_READY.
REQ-022 Full FIFO with push and no pop -> event dropped, OVF set, BTN_LEVEL still updated.
REQ-023 Full FIFO with simultaneous push and pop -> both performed, no drop.
REQ-024 Empty FIFO: EVT_VALID low; EVT_READY ignored; no underflow.
REQ-025 OVF clears only on reset.

Reset
REQ-026 RST_N low SHALL asynchronously clear: synchronizers, BTN_LEVEL=0, timer=0, PTR=0, FSM=SCAN, FIFO empty (EVT_VALID=0, EVT_ID=0, EVT_PRESS=0), OVF=0.
REQ-027 Reset during QUAL SHALL discard the qualification; no event generated.
REQ-028 Release is synchronous to CLK internally; first scan on second edge after RST_N rises.
REQ-029 A button held at reset release is qualified as a normal press (event generated).

Configuration
REQ-030 Macro BTN_RELEASE_EVT_EN defined: REPORT pushes both press (EVT_PRESS=1) and release (EVT_PRESS=0) events.
REQ-031 Macro undefined: only press events pushed; releases update BTN_LEVEL silently; EVT_PRESS tied 1.

Verification (bench DEBOUNCE_CNT=16, N_BTN=4, FIFO_DEPTH=4)
REQ-032 BTN_IN[2] 0->1 held 40 cycles, EVT_READY=1 -> BTN_LEVEL[2] rises 16 cycles after QUAL entry; one event ID=2 PRESS=1; OVF=0.
REQ-033 BTN_IN[1] pulses high 10 cycles, three times with 3-cycle gaps -> BTN_LEVEL stays 0, no events.
REQ-034 EVT_READY=0, buttons 0..3 pressed then 0 released (macro on) -> 4 events queued IDs 0,1,2,3; release dropped, OVF=1, BTN_LEVEL[0]=0.
REQ-035 Buttons 0 and 3 rise same cycle -> two events, ID order follows PTR position, each 16 stable cycles apart minimum.
REQ-036 RST_N pulsed low at timer=8 in QUAL for button 1 -> all outputs 0 immediately; after release, button still high -> press event after full 16-cycle requalification.
REQ-037 Macro off, press then release button 0 -> exactly one event (PRESS=1); BTN_LEVEL[0] returns 0.

Source files
------------

// File: rtl/btn_scan_ctrl_if.sv
// Button scanner bundle: raw button levels in, debounced levels and the event FIFO head out.
interface btn_scan_ctrl_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] BTN_IN;
   logic [N_BTN-1:0] BTN_LEVEL;
   logic             EVT_VALID;
   logic             EVT_READY;
   logic [2:0]       EVT_ID;
   logic             EVT_PRESS;
   logic             OVF;

   modport master (
      output BTN_IN, EVT_READY,
      input  BTN_LEVEL, EVT_VALID, EVT_ID, EVT_PRESS, OVF
   );

   modport slave (
      input  BTN_IN, EVT_READY,
      output BTN_LEVEL, EVT_VALID, EVT_ID, EVT_PRESS, OVF
   );
endinterface

// File: rtl/btn_scan_ctrl.sv
// Debounced button scanner: one shared stability timer, round-robin scan FSM, press/release event FIFO.
// Define BTN_RELEASE_EVT_EN to also queue release events; otherwise only presses are queued.
module btn_scan_sync (
   input  logic CLK,
   input  logic RST_N,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module btn_scan_ctrl #(
   parameter int N_BTN        = 4,
   parameter int DEBOUNCE_CNT = 20'hFFFF,
   parameter int FIFO_DEPTH   = 4
) (
   input logic           CLK,
   input logic           RST_N,
   btn_scan_ctrl_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef BTN_RELEASE_EVT_EN
   localparam int EW = 4;
`else
   localparam int EW = 3;
`endif
   localparam logic [19:0] T_LAST = 20'(DEBOUNCE_CNT - 1);
   localparam logic [2:0]  P_LAST = 3'(N_BTN - 1);

   typedef enum logic [1:0] {SCAN, QUAL, REPORT} state_t;

   state_t           state;
   logic [2:0]       ptr, ptr_nxt;
   logic [19:0]      timer;
   logic             run;
   logic [N_BTN-1:0] btn_sync, btn_level, ptr_hot;
   logic             cur_sync, cur_level;

   logic             push_req, do_push, pop, empty, full, ovf;
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [EW-1:0]    wr_data, head;

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_sync
         btn_scan_sync u_sync (
            .CLK  (CLK),
            .RST_N(RST_N),
            .d    (bus.BTN_IN[i]),
            .q    (btn_sync[i])
         );
      end
   endgenerate

   always_comb begin
      ptr_hot   = '0;
      cur_sync  = 1'b0;
      cur_level = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (ptr == 3'(i)) begin
            ptr_hot[i] = 1'b1;
            cur_sync   = btn_sync[i];
            cur_level  = btn_level[i];
         end
      end
   end

   assign ptr_nxt = (ptr == P_LAST) ? 3'd0 : ptr + 3'd1;

   // run holds the FSM off for one edge so reset release is seen synchronously
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         run       <= 1'b0;
         state     <= SCAN;
         ptr       <= 3'd0;
         timer     <= 20'd0;
         btn_level <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            case (state)
               SCAN: begin
                  if (cur_sync != cur_level) begin
                     state <= QUAL;
                     timer <= 20'd0;
                  end else begin
                     ptr <= ptr_nxt;
                  end
               end
               QUAL: begin
                  if (cur_sync == cur_level) begin
                     state <= SCAN;
                     ptr   <= ptr_nxt;
                  end else if (timer == T_LAST) begin
                     btn_level <= btn_level ^ ptr_hot;
                     state     <= REPORT;
                  end else begin
                     timer <= timer + 20'd1;
                  end
               end
               REPORT: begin
                  ptr   <= ptr_nxt;
                  state <= SCAN;
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   // In REPORT the level has already toggled, so cur_level is the new level
`ifdef BTN_RELEASE_EVT_EN
   assign push_req = (state == REPORT);
   assign wr_data  = {ptr, cur_level};
`else
   assign push_req = (state == REPORT) && cur_level;
   assign wr_data  = ptr;
`endif

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && bus.EVT_READY;
   assign do_push = push_req && (!full || pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push_req && full && !pop)
            ovf <= 1'b1;
      end
   end

   // Full with a same-cycle pop writes into the slot being vacated
   always_ff @(posedge CLK) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign bus.BTN_LEVEL = btn_level;
   assign bus.EVT_VALID = !empty;
   assign bus.EVT_ID    = empty ? 3'd0 : head[EW-1 -: 3];
`ifdef BTN_RELEASE_EVT_EN
   assign bus.EVT_PRESS = !empty && head[0];
`else
   assign bus.EVT_PRESS = 1'b1;
`endif
   assign bus.OVF       = ovf;
endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl: directed scenarios plus randomized bouncing buttons.
module tb_btn_scan_ctrl;
   localparam int N     = 4;
   localparam int D     = 16;
   localparam int DEPTH = 4;
`ifdef BTN_RELEASE_EVT_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif
   localparam int LAT_LO = D + 3;
   localparam int LAT_HI = D + N + 2;

   typedef struct {
      logic [2:0] id;
      logic       press;
      int         grp;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   btn_scan_ctrl_if #(.N_BTN(N)) bus ();

   btn_scan_ctrl #(.N_BTN(N), .DEBOUNCE_CNT(D), .FIFO_DEPTH(DEPTH)) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   exp_t       sbq[$];
   int         total = 0;
   int         bad = 0;
   logic [N-1:0] lvl_m = '0;
   bit         stall_m = 0;
   int         occ_m = 0;
   bit         ovf_m = 0;
   bit         rnd_ready = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: an event exists for every accepted level change that is a press
   // (or any change when releases are enabled); a stalled FIFO holds DEPTH entries.
   task automatic expect_evt(input int id, input logic lvl, input int grp);
      exp_t e;
      lvl_m[id] = lvl;
      if (!(lvl || REL)) return;
      if (stall_m) begin
         if (occ_m == DEPTH) begin
            ovf_m = 1'b1;
            return;
         end
         occ_m++;
      end
      e.id = id[2:0];
      e.press = lvl;
      e.grp = grp;
      sbq.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_level(input int b, input logic v, input string nm);
      int n = 0;
      bit seen = 0;
      while (n < LAT_HI + 8 && !seen) begin
         @(posedge CLK);
         #1;
         n++;
         if (bus.BTN_LEVEL[b] === v) seen = 1;
      end
      total++;
      if (!seen || n < LAT_LO || n > LAT_HI) begin
         bad++;
         $display("FAIL %s: level change after %0d edges (seen=%0d) expected %0d..%0d",
                  nm, n, seen, LAT_LO, LAT_HI);
      end
   endtask

   task automatic change(input int b, input logic v, input string nm);
      bus.BTN_IN[b] = v;
      expect_evt(b, v, 0);
      wait_level(b, v, nm);
   endtask

   // Monitor: pops the scoreboard on every accepted event, checks head stability on stalls
   logic [2:0] held_id;
   logic       held_p;
   bit         held_v = 0;
   always @(negedge CLK) begin
      if (!RST_N || !bus.EVT_VALID) begin
         held_v = 0;
      end else begin
         if (held_v) begin
            chk("hold_id", 32'(bus.EVT_ID), 32'(held_id));
            chk("hold_press", 32'(bus.EVT_PRESS), 32'(held_p));
         end
         if (bus.EVT_READY) begin
            held_v = 0;
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_evt: got id=%0d press=%0d expected none",
                        bus.EVT_ID, bus.EVT_PRESS);
            end else begin
               int hit = -1;
               if (sbq[0].grp == 0) begin
                  if (sbq[0].id == bus.EVT_ID && sbq[0].press == bus.EVT_PRESS) hit = 0;
               end else begin
                  for (int i = 0; i < sbq.size() && sbq[i].grp == sbq[0].grp; i++)
                     if (hit < 0 && sbq[i].id == bus.EVT_ID && sbq[i].press == bus.EVT_PRESS)
                        hit = i;
               end
               if (hit < 0) begin
                  bad++;
                  $display("FAIL evt: got id=%0d press=%0d expected id=%0d press=%0d",
                           bus.EVT_ID, bus.EVT_PRESS, sbq[0].id, sbq[0].press);
                  hit = 0;
               end
               sbq.delete(hit);
            end
         end else begin
            held_v  = 1;
            held_id = bus.EVT_ID;
            held_p  = bus.EVT_PRESS;
         end
      end
   end

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (rnd_ready) bus.EVT_READY = ($urandom % 4) != 0;
      end
   end

   initial begin
      int t0, t3;
      bus.BTN_IN = '0;
      bus.EVT_READY = 1'b1;
      RST_N = 1'b0;
      tick(3);
      chk("rst_level", 32'(bus.BTN_LEVEL), 0);
      chk("rst_valid", 32'(bus.EVT_VALID), 0);
      chk("rst_id", 32'(bus.EVT_ID), 0);
      chk("rst_ovf", 32'(bus.OVF), 0);
`ifdef BTN_RELEASE_EVT_EN
      chk("rst_press", 32'(bus.EVT_PRESS), 0);
`endif
      RST_N = 1'b1;
      tick(5);

      // single press and release on button 2
      change(2, 1'b1, "lat_press2");
      tick(20);
      chk("ovf_press2", 32'(bus.OVF), 0);
      change(2, 1'b0, "lat_release2");
      tick(10);

      // bouncing pulses shorter than the debounce window are rejected
      repeat (3) begin
         bus.BTN_IN[1] = 1'b1;
         tick(10);
         bus.BTN_IN[1] = 1'b0;
         tick(3);
      end
      tick(30);
      chk("glitch_level", 32'(bus.BTN_LEVEL), 32'(lvl_m));

      // buttons 0 and 3 rise together; qualification is serialized
      bus.BTN_IN[0] = 1'b1;
      bus.BTN_IN[3] = 1'b1;
      expect_evt(0, 1'b1, 1);
      expect_evt(3, 1'b1, 1);
      t0 = -1;
      t3 = -1;
      for (int n = 1; n <= 150 && (t0 < 0 || t3 < 0); n++) begin
         @(posedge CLK);
         #1;
         if (bus.BTN_LEVEL[0] && t0 < 0) t0 = n;
         if (bus.BTN_LEVEL[3] && t3 < 0) t3 = n;
      end
      chk("dual_both", 32'(t0 > 0 && t3 > 0), 1);
      total++;
      if ((t0 > t3 ? t0 - t3 : t3 - t0) < D) begin
         bad++;
         $display("FAIL dual_spacing: got %0d edges apart expected >= %0d", t0 - t3, D);
      end
      bus.BTN_IN[0] = 1'b0;
      bus.BTN_IN[3] = 1'b0;
      expect_evt(0, 1'b0, 2);
      expect_evt(3, 1'b0, 2);
      tick(90);
      chk("dual_release_level", 32'(bus.BTN_LEVEL), 32'(lvl_m));

      // reset in the middle of qualifying button 1
      tick(10);
      chk("q_empty_before_rst", 32'(sbq.size()), 0);
      bus.BTN_IN[1] = 1'b1;
      tick(11);
      RST_N = 1'b0;
      #1;
      chk("midq_rst_level", 32'(bus.BTN_LEVEL), 0);
      chk("midq_rst_valid", 32'(bus.EVT_VALID), 0);
      chk("midq_rst_ovf", 32'(bus.OVF), 0);
      lvl_m = '0;
      tick(2);
      RST_N = 1'b1;
      expect_evt(1, 1'b1, 0);
      wait_level(1, 1'b1, "requal_press1");
      tick(5);
      change(1, 1'b0, "requal_release1");
      tick(10);

      // stalled consumer: four presses fill the FIFO, later events are dropped
      bus.EVT_READY = 1'b0;
      stall_m = 1;
      occ_m = 0;
      for (int b = 0; b < N; b++) change(b, 1'b1, "stall_press");
      change(0, 1'b0, "stall_release0");
      chk("stall_lvl0", 32'(bus.BTN_LEVEL[0]), 0);
      change(0, 1'b1, "stall_repress0");
      tick(3);
      chk("stall_valid", 32'(bus.EVT_VALID), 1);
      chk("stall_head", 32'(bus.EVT_ID), 0);
      chk("stall_ovf", 32'(bus.OVF), 32'(ovf_m));
      stall_m = 0;
      bus.EVT_READY = 1'b1;
      tick(10);
      for (int b = 0; b < N; b++) change(b, 1'b0, "drain_release");

      // press then release button 0
      change(0, 1'b1, "p37_press");
      change(0, 1'b0, "p37_release");
      tick(4);
      chk("p37_level", 32'(bus.BTN_LEVEL[0]), 0);

      // randomized bouncing transitions with a random consumer
      rnd_ready = 1;
      repeat (24) begin
         int   b;
         logic nv;
         b = $urandom_range(0, N - 1);
         nv = ~lvl_m[b];
         repeat ($urandom_range(0, 3)) begin
            bus.BTN_IN[b] = nv;
            tick($urandom_range(1, 10));
            bus.BTN_IN[b] = ~nv;
            tick($urandom_range(1, 5));
         end
         change(b, nv, "rnd_settle");
         tick($urandom_range(2, 8));
      end
      rnd_ready = 0;
      #1;
      bus.EVT_READY = 1'b1;
      for (int n = 0; n < 200 && sbq.size() != 0; n++) tick(1);
      tick(4);
      chk("sb_drained", 32'(sbq.size()), 0);
      chk("final_level", 32'(bus.BTN_LEVEL), 32'(lvl_m));
      chk("final_ovf", 32'(bus.OVF), 32'(ovf_m));
      chk("final_valid", 32'(bus.EVT_VALID), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
